// File: rtl/arc4_pkg.sv
// Shared types and widths for the ARC4 control slice.
// ARC4_CTRL_TIMEOUT_EN adds the ERR state used by the per-phase watchdog.
package arc4_pkg;

  localparam int ARC4_KEY_W  = 24;
  localparam int ARC4_ADDR_W = 8;
  localparam int ARC4_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    INIT_REQ,
    INIT_WAIT,
    KSA_REQ,
    KSA_WAIT,
    PRGA_REQ,
    PRGA_WAIT
`ifdef ARC4_CTRL_TIMEOUT_EN
    , ERR
`endif
  } arc4_ctrl_state_t;

  typedef enum logic [1:0] {
    SEL_INIT,
    SEL_KSA,
    SEL_PRGA
  } arc4_sel_t;

endpackage

// File: rtl/arc4_ctrl_if.sv
// S-memory request bundle: three sub-block request ports in, one memory port out.
// Handshake-free: the controller picks a source (sel) and enables writes (gate).
interface arc4_ctrl_if;
  import arc4_pkg::*;

  logic [ARC4_ADDR_W-1:0] init_addr, ksa_addr, prga_addr;
  logic [ARC4_DATA_W-1:0] init_wrdata, ksa_wrdata, prga_wrdata;
  logic                   init_wren, ksa_wren, prga_wren;
  arc4_sel_t              sel;
  logic                   gate;
  logic [ARC4_ADDR_W-1:0] s_addr;
  logic [ARC4_DATA_W-1:0] s_wrdata;
  logic                   s_wren;

  modport master (
    output init_addr, ksa_addr, prga_addr,
    output init_wrdata, ksa_wrdata, prga_wrdata,
    output init_wren, ksa_wren, prga_wren,
    output sel, gate,
    input  s_addr, s_wrdata, s_wren
  );

  modport slave (
    input  init_addr, ksa_addr, prga_addr,
    input  init_wrdata, ksa_wrdata, prga_wrdata,
    input  init_wren, ksa_wren, prga_wren,
    input  sel, gate,
    output s_addr, s_wrdata, s_wren
  );

endinterface

// File: rtl/arc4_mem_mux.sv
// 3:1 S-memory port mux; write enable is gated so an idle or failed
// controller can never write memory.
module arc4_mem_mux
  import arc4_pkg::*;
(
  arc4_ctrl_if.slave bus
);

  logic wren;

  always_comb begin
    bus.s_addr   = bus.init_addr;
    bus.s_wrdata = bus.init_wrdata;
    wren         = bus.init_wren;
    case (bus.sel)
      SEL_KSA: begin
        bus.s_addr   = bus.ksa_addr;
        bus.s_wrdata = bus.ksa_wrdata;
        wren         = bus.ksa_wren;
      end
      SEL_PRGA: begin
        bus.s_addr   = bus.prga_addr;
        bus.s_wrdata = bus.prga_wrdata;
        wren         = bus.prga_wren;
      end
      default: ;
    endcase
    bus.s_wren = wren & bus.gate;
  end

endmodule

// File: rtl/arc4_ctrl.sv
// ARC4 phase sequencer: runs init, ksa, prga in order and owns the S-memory port.
// Define ARC4_CTRL_TIMEOUT_EN to add the per-phase watchdog and sticky err.
module arc4_ctrl
  import arc4_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [ARC4_KEY_W-1:0]  key,
  output logic                   err,
  output logic                   init_en,
  output logic                   ksa_en,
  output logic                   prga_en,
  input  logic                   init_rdy,
  input  logic                   ksa_rdy,
  input  logic                   prga_rdy,
  output logic [ARC4_KEY_W-1:0]  ksa_key,
  output logic [ARC4_KEY_W-1:0]  prga_key,
  input  logic [ARC4_ADDR_W-1:0] init_addr,
  input  logic [ARC4_ADDR_W-1:0] ksa_addr,
  input  logic [ARC4_ADDR_W-1:0] prga_addr,
  input  logic [ARC4_DATA_W-1:0] init_wrdata,
  input  logic [ARC4_DATA_W-1:0] ksa_wrdata,
  input  logic [ARC4_DATA_W-1:0] prga_wrdata,
  input  logic                   init_wren,
  input  logic                   ksa_wren,
  input  logic                   prga_wren,
  output logic [ARC4_ADDR_W-1:0] s_addr,
  output logic [ARC4_DATA_W-1:0] s_wrdata,
  output logic                   s_wren,
  output arc4_ctrl_state_t       dbg_state
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("arc4_ctrl: TIMEOUT_CYCLES must fit the 16-bit watchdog counter");
  end

  arc4_ctrl_state_t      state_q, state_d;
  arc4_sel_t             sel_q, sel_d;
  logic [ARC4_KEY_W-1:0] key_q;
  logic                  load_key, mem_gate;
  logic                  init_en_d, ksa_en_d, prga_en_d;
  logic                  in_wait, phase_rdy, seen_low_q, done, wait_entry;
  logic                  timeout;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    load_key  = 1'b0;
    init_en_d = 1'b0;
    ksa_en_d  = 1'b0;
    prga_en_d = 1'b0;
    in_wait   = 1'b0;
    phase_rdy = 1'b0;
    mem_gate  = 1'b1;
    case (state_q)
      INIT_REQ, INIT_WAIT: phase_rdy = init_rdy;
      KSA_REQ, KSA_WAIT:   phase_rdy = ksa_rdy;
      PRGA_REQ, PRGA_WAIT: phase_rdy = prga_rdy;
      default:             phase_rdy = 1'b0;
    endcase
    in_wait = (state_q == INIT_WAIT) || (state_q == KSA_WAIT) || (state_q == PRGA_WAIT);
    // Completion needs a low-then-high on ready so a stale ready is not taken as done.
    done = in_wait && phase_rdy && seen_low_q;
    case (state_q)
      IDLE: begin
        mem_gate = 1'b0;
        if (en) begin
          load_key = 1'b1;
          sel_d    = SEL_INIT;
          state_d  = INIT_REQ;
        end
      end
      INIT_REQ:  if (init_rdy) begin init_en_d = 1'b1; state_d = INIT_WAIT; end
      INIT_WAIT: if (done) begin sel_d = SEL_KSA; state_d = KSA_REQ; end
      KSA_REQ:   if (ksa_rdy) begin ksa_en_d = 1'b1; state_d = KSA_WAIT; end
      KSA_WAIT:  if (done) begin sel_d = SEL_PRGA; state_d = PRGA_REQ; end
      PRGA_REQ:  if (prga_rdy) begin prga_en_d = 1'b1; state_d = PRGA_WAIT; end
      PRGA_WAIT: if (done) state_d = IDLE;
`ifdef ARC4_CTRL_TIMEOUT_EN
      ERR:       mem_gate = 1'b0;
`endif
      default:   state_d = IDLE;
    endcase
`ifdef ARC4_CTRL_TIMEOUT_EN
    if (timeout) state_d = ERR;
`endif
  end

  assign wait_entry = init_en_d | ksa_en_d | prga_en_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= SEL_INIT;
      key_q      <= '0;
      init_en    <= 1'b0;
      ksa_en     <= 1'b0;
      prga_en    <= 1'b0;
      seen_low_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      init_en <= init_en_d;
      ksa_en  <= ksa_en_d;
      prga_en <= prga_en_d;
      if (load_key) key_q <= key;
      if (wait_entry) seen_low_q <= 1'b0;
      else if (in_wait && !phase_rdy) seen_low_q <= 1'b1;
    end
  end

`ifdef ARC4_CTRL_TIMEOUT_EN
  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q;
  logic        err_q;

  assign timeout = in_wait && !done && (cnt_q == WDOG_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (wait_entry) cnt_q <= '0;
      else if (in_wait) cnt_q <= cnt_q + 16'd1;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  arc4_ctrl_if bus ();

  assign bus.init_addr   = init_addr;
  assign bus.ksa_addr    = ksa_addr;
  assign bus.prga_addr   = prga_addr;
  assign bus.init_wrdata = init_wrdata;
  assign bus.ksa_wrdata  = ksa_wrdata;
  assign bus.prga_wrdata = prga_wrdata;
  assign bus.init_wren   = init_wren;
  assign bus.ksa_wren    = ksa_wren;
  assign bus.prga_wren   = prga_wren;
  assign bus.sel         = sel_q;
  assign bus.gate        = mem_gate;

  arc4_mem_mux u_mem_mux (.bus(bus));

  assign s_addr    = bus.s_addr;
  assign s_wrdata  = bus.s_wrdata;
  assign s_wren    = bus.s_wren;
  assign rdy       = (state_q == IDLE);
  assign ksa_key   = key_q;
  assign prga_key  = key_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_arc4_ctrl.sv
// Directed bench for arc4_ctrl with mock init/ksa/prga responders.
// Watchdog scenario runs only when ARC4_CTRL_TIMEOUT_EN is defined.
module tb_arc4_ctrl;
  import arc4_pkg::*;

  logic             clk = 1'b0;
  logic             rst, mock_rst, en;
  logic [23:0]      key;
  logic             rdy, err, init_en, ksa_en, prga_en;
  logic             init_rdy, ksa_rdy, prga_rdy;
  logic [23:0]      ksa_key, prga_key;
  arc4_ctrl_state_t dbg_state;
  arc4_ctrl_if      mem_bus ();

  int checks = 0, errors = 0, cyc = 0;
  int init_lat = 4, ksa_lat = 4, prga_lat = 4, ksa_stale = 0;
  bit prga_hang = 1'b0, mon_on = 1'b0;
  int init_cnt, ksa_cnt, ksa_st, prga_cnt;
  int init_pulses = 0, ksa_pulses = 0, prga_pulses = 0;
  int init_cyc = 0, ksa_cyc = 0, prga_cyc = 0;
  int overlap = 0, busy_samples = 0, mux_bad = 0, aa_seen = 0, stale_bad = 0;
  logic ksa_busy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arc4_ctrl #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .err(err),
    .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
    .ksa_key(ksa_key), .prga_key(prga_key),
    .init_addr(mem_bus.init_addr), .ksa_addr(mem_bus.ksa_addr), .prga_addr(mem_bus.prga_addr),
    .init_wrdata(mem_bus.init_wrdata), .ksa_wrdata(mem_bus.ksa_wrdata),
    .prga_wrdata(mem_bus.prga_wrdata),
    .init_wren(mem_bus.init_wren), .ksa_wren(mem_bus.ksa_wren), .prga_wren(mem_bus.prga_wren),
    .s_addr(mem_bus.s_addr), .s_wrdata(mem_bus.s_wrdata), .s_wren(mem_bus.s_wren),
    .dbg_state(dbg_state)
  );

  // Mock memory traffic: init writes 8'hAA constantly, ksa never produces 8'hAA.
  assign mem_bus.init_addr   = 8'hAA;
  assign mem_bus.init_wrdata = 8'h11;
  assign mem_bus.init_wren   = 1'b1;
  assign mem_bus.ksa_addr    = {1'b0, ksa_cnt[6:0]};
  assign mem_bus.ksa_wrdata  = ksa_cnt[7:0] ^ 8'h5C;
  assign mem_bus.ksa_wren    = ksa_cnt[0];
  assign mem_bus.prga_addr   = 8'hC3;
  assign mem_bus.prga_wrdata = 8'h33;
  assign mem_bus.prga_wren   = 1'b0;
  assign mem_bus.sel         = SEL_INIT;
  assign mem_bus.gate        = 1'b0;
  assign ksa_busy = (ksa_st != 0) || (ksa_cnt != 0);

  always @(posedge clk or posedge mock_rst) begin
    if (mock_rst) begin init_rdy <= 1'b1; init_cnt <= 0; end
    else if (init_en) begin init_rdy <= 1'b0; init_cnt <= init_lat; end
    else if (init_cnt > 0) begin init_cnt <= init_cnt - 1; if (init_cnt == 1) init_rdy <= 1'b1; end
  end

  always @(posedge clk or posedge mock_rst) begin
    if (mock_rst) begin ksa_rdy <= 1'b1; ksa_cnt <= 0; ksa_st <= 0; end
    else if (ksa_en) begin
      ksa_cnt <= ksa_lat;
      ksa_st  <= ksa_stale;
      if (ksa_stale == 0) ksa_rdy <= 1'b0;
    end
    else if (ksa_st > 0) begin ksa_st <= ksa_st - 1; if (ksa_st == 1) ksa_rdy <= 1'b0; end
    else if (ksa_cnt > 0) begin ksa_cnt <= ksa_cnt - 1; if (ksa_cnt == 1) ksa_rdy <= 1'b1; end
  end

  always @(posedge clk or posedge mock_rst) begin
    if (mock_rst) begin prga_rdy <= 1'b1; prga_cnt <= 0; end
    else if (prga_en) begin prga_rdy <= 1'b0; prga_cnt <= prga_hang ? 0 : prga_lat; end
    else if (prga_cnt > 0) begin prga_cnt <= prga_cnt - 1; if (prga_cnt == 1) prga_rdy <= 1'b1; end
  end

  always @(negedge clk) begin
    if (init_en) begin init_pulses <= init_pulses + 1; init_cyc <= cyc; end
    if (ksa_en) begin ksa_pulses <= ksa_pulses + 1; ksa_cyc <= cyc; end
    if (prga_en) begin prga_pulses <= prga_pulses + 1; prga_cyc <= cyc; end
    if (int'(init_en) + int'(ksa_en) + int'(prga_en) > 1) overlap <= overlap + 1;
    if (mon_on && ksa_busy) begin
      busy_samples <= busy_samples + 1;
      if (mem_bus.s_addr !== mem_bus.ksa_addr || mem_bus.s_wren !== mem_bus.ksa_wren ||
          mem_bus.s_wrdata !== mem_bus.ksa_wrdata) mux_bad <= mux_bad + 1;
      if (mem_bus.s_addr === 8'hAA) aa_seen <= aa_seen + 1;
      if (dbg_state !== KSA_WAIT || prga_en) stale_bad <= stale_bad + 1;
    end
  end

  task automatic start_run(input logic [23:0] k, output int n);
    @(negedge clk);
    en = 1'b1;
    key = k;
    @(posedge clk);
    #1 n = cyc;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_rdy(input int budget, output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rdy) begin ok = 1'b1; at = cyc; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mock_rst = 1'b1; en = 1'b0; key = '0;
    repeat (3) @(negedge clk);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %0b, expected 1", rdy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b, expected 0", err); end
    mock_rst = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL idle_rdy: got %0b, expected 1", rdy); end
      checks++; if (mem_bus.s_wren !== 1'b0) begin errors++; $display("FAIL idle_s_wren: got %0b, expected 0", mem_bus.s_wren); end
      checks++; if ({init_en, ksa_en, prga_en} !== 3'b000) begin errors++; $display("FAIL idle_en: got %b, expected 000", {init_en, ksa_en, prga_en}); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL idle_err: got %0b, expected 0", err); end
    end
    checks++; if (ksa_key !== 24'h0) begin errors++; $display("FAIL idle_key: got %h, expected 000000", ksa_key); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL idle_state: got %0d, expected %0d", dbg_state, IDLE); end
  endtask

  task automatic test_full_sequence();
    int n, at, p_i, p_k, p_p, p_o;
    bit ok;
    init_lat = 256; ksa_lat = 768; prga_lat = 32; ksa_stale = 0; mon_on = 1'b1;
    p_i = init_pulses; p_k = ksa_pulses; p_p = prga_pulses; p_o = overlap;
    start_run(24'h000311, n);
    repeat (5) @(negedge clk);
    key = 24'hFFFFFF;
    wait_rdy(3000, ok, at);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full_done: rdy never returned, expected 1"); end
    checks++; if (init_pulses - p_i != 1) begin errors++; $display("FAIL full_init_pulses: got %0d, expected 1", init_pulses - p_i); end
    checks++; if (ksa_pulses - p_k != 1) begin errors++; $display("FAIL full_ksa_pulses: got %0d, expected 1", ksa_pulses - p_k); end
    checks++; if (prga_pulses - p_p != 1) begin errors++; $display("FAIL full_prga_pulses: got %0d, expected 1", prga_pulses - p_p); end
    checks++; if (init_cyc != n + 1) begin errors++; $display("FAIL full_init_cyc: got %0d, expected %0d", init_cyc, n + 1); end
    checks++; if (ksa_cyc != init_cyc + 256 + 3) begin errors++; $display("FAIL full_ksa_cyc: got %0d, expected %0d", ksa_cyc, init_cyc + 259); end
    checks++; if (prga_cyc != ksa_cyc + 768 + 3) begin errors++; $display("FAIL full_prga_cyc: got %0d, expected %0d", prga_cyc, ksa_cyc + 771); end
    checks++; if (at != prga_cyc + 32 + 2) begin errors++; $display("FAIL full_rdy_cyc: got %0d, expected %0d", at, prga_cyc + 34); end
    checks++; if (ksa_key !== 24'h000311) begin errors++; $display("FAIL full_ksa_key: got %h, expected 000311", ksa_key); end
    checks++; if (prga_key !== 24'h000311) begin errors++; $display("FAIL full_prga_key: got %h, expected 000311", prga_key); end
    checks++; if (overlap != p_o) begin errors++; $display("FAIL full_overlap: got %0d, expected %0d", overlap, p_o); end
  endtask

  task automatic test_mux_isolation();
    checks++; if (busy_samples == 0) begin errors++; $display("FAIL mux_samples: got 0, expected >0"); end
    checks++; if (mux_bad != 0) begin errors++; $display("FAIL mux_ksa_route: got %0d bad cycles, expected 0", mux_bad); end
    checks++; if (aa_seen != 0) begin errors++; $display("FAIL mux_aa_leak: got %0d cycles, expected 0", aa_seen); end
  endtask

  task automatic test_stale_ready();
    int n, at, p_p, s0;
    bit ok;
    init_lat = 5; ksa_lat = 10; ksa_stale = 3; prga_lat = 4;
    p_p = prga_pulses; s0 = stale_bad;
    start_run(24'h00BEEF, n);
    wait_rdy(500, ok, at);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stale_done: rdy never returned, expected 1"); end
    checks++; if (prga_cyc != ksa_cyc + 1 + 3 + 10 + 2) begin errors++; $display("FAIL stale_prga_cyc: got %0d, expected %0d", prga_cyc, ksa_cyc + 16); end
    checks++; if (stale_bad != s0) begin errors++; $display("FAIL stale_early_exit: got %0d, expected %0d", stale_bad, s0); end
    checks++; if (prga_pulses - p_p != 1) begin errors++; $display("FAIL stale_prga_pulses: got %0d, expected 1", prga_pulses - p_p); end
    ksa_stale = 0;
  endtask

  task automatic test_back_to_back();
    int n, at, p_i, p_k, p_p;
    bit ok, seen;
    init_lat = 8; ksa_lat = 20; prga_lat = 6;
    p_i = init_pulses; p_k = ksa_pulses; p_p = prga_pulses;
    start_run(24'hABCDEF, n);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); seen = ksa_busy; end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL busy_ksa_start: ksa never started, expected start"); end
    en = 1'b1; key = 24'h123456;
    @(negedge clk);
    en = 1'b0;
    wait_rdy(500, ok, at);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL busy_done: rdy never returned, expected 1"); end
    repeat (5) @(negedge clk);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL busy_no_queue_rdy: got %0b, expected 1", rdy); end
    checks++; if (init_pulses - p_i != 1) begin errors++; $display("FAIL busy_init_pulses: got %0d, expected 1", init_pulses - p_i); end
    checks++; if (ksa_pulses - p_k != 1) begin errors++; $display("FAIL busy_ksa_pulses: got %0d, expected 1", ksa_pulses - p_k); end
    checks++; if (prga_pulses - p_p != 1) begin errors++; $display("FAIL busy_prga_pulses: got %0d, expected 1", prga_pulses - p_p); end
    checks++; if (ksa_key !== 24'hABCDEF) begin errors++; $display("FAIL busy_key: got %h, expected abcdef", ksa_key); end
    start_run(24'h0F0F0F, n);
    wait_rdy(500, ok, at);
    checks++; if (init_cyc != n + 1) begin errors++; $display("FAIL b2b_init_cyc: got %0d, expected %0d", init_cyc, n + 1); end
    checks++; if (prga_key !== 24'h0F0F0F) begin errors++; $display("FAIL b2b_key: got %h, expected 0f0f0f", prga_key); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    bit seen;
    init_lat = 4; ksa_lat = 40; prga_lat = 4;
    start_run(24'h5A5A5A, n);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); seen = ksa_busy && mem_bus.ksa_wren; end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_ksa_write: no ksa write seen, expected one"); end
    checks++; if (mem_bus.s_wren !== 1'b1) begin errors++; $display("FAIL rst_pre_s_wren: got %0b, expected 1", mem_bus.s_wren); end
    mon_on = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy: got %0b, expected 1", rdy); end
    checks++; if (mem_bus.s_wren !== 1'b0) begin errors++; $display("FAIL rst_s_wren: got %0b, expected 0", mem_bus.s_wren); end
    checks++; if (ksa_key !== 24'h0) begin errors++; $display("FAIL rst_key: got %h, expected 000000", ksa_key); end
    checks++; if ({init_en, ksa_en, prga_en} !== 3'b000) begin errors++; $display("FAIL rst_en: got %b, expected 000", {init_en, ksa_en, prga_en}); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100 && ksa_busy; i++) @(negedge clk);
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_stays_idle: got %0d, expected %0d", dbg_state, IDLE); end
    mon_on = 1'b1;
  endtask

`ifdef ARC4_CTRL_TIMEOUT_EN
  task automatic test_watchdog();
    int n, p;
    bit seen;
    init_lat = 4; ksa_lat = 4; prga_hang = 1'b1;
    start_run(24'h777777, n);
    seen = 1'b0; p = 0;
    for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); if (prga_en) begin seen = 1'b1; p = cyc; end end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL wd_prga_start: no prga_en, expected one"); end
    for (int i = 0; i < 200 && cyc < p + 99; i++) @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wd_err_early: got %0b, expected 0", err); end
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd_err: got %0b, expected 1", err); end
    checks++; if (dbg_state !== ERR) begin errors++; $display("FAIL wd_state: got %0d, expected %0d", dbg_state, ERR); end
    repeat (5) @(negedge clk);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL wd_rdy_held: got %0b, expected 0", rdy); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd_err_sticky: got %0b, expected 1", err); end
    rst = 1'b1; mock_rst = 1'b1; prga_hang = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wd_rst_err: got %0b, expected 0", err); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL wd_rst_rdy: got %0b, expected 1", rdy); end
    @(negedge clk);
    rst = 1'b0; mock_rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_full_sequence();
    test_mux_isolation();
    test_stale_ready();
    test_back_to_back();
    test_reset_mid_run();
`ifdef ARC4_CTRL_TIMEOUT_EN
    test_watchdog();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
